// File: rtl/bcd_counter_multi.sv
// Parametrised multi-digit BCD up/down counter with clear, validated parallel load,
// terminal count and wrap pulse. Define BCD_CNT_SAT_EN to saturate instead of wrapping.
module bcd_counter_multi #(
    parameter int DIGITS  = 2,
    parameter int RST_VAL = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                up_dn,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                wrap,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] res;
        int           v;
        res = '0;
        v   = value;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(v % 10);
            v             = v / 10;
        end
        return res;
    endfunction

    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    // Returns {ripple-out, next value}; ripple-out set means every digit rolled over.
    function automatic logic [W:0] bcd_step(input logic [W-1:0] v, input logic up);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (up) begin
                    if (v[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        c           = 1'b0;
                    end
                end else begin
                    if (v[4*i +: 4] == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        c           = 1'b0;
                    end
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return {c, r};
    endfunction

    localparam logic [W-1:0] RST_BCD  = to_bcd(RST_VAL);
    localparam logic [W-1:0] ALL_NINE = {DIGITS{4'h9}};
    localparam logic [W-1:0] ALL_ZERO = '0;

    logic [W-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;
    logic         load_err_q, load_err_d;
    logic [W:0]   step_s;

    assign step_s = bcd_step(count_q, up_dn);

    // Next-state selection with priority clr > load > en.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (clr) begin
            count_d = RST_BCD;
        end else if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (is_bcd(load_val[4*i +: 4])) begin
                    count_d[4*i +: 4] = load_val[4*i +: 4];
                end else begin
                    count_d[4*i +: 4] = 4'd0;
                    load_err_d        = 1'b1;
                end
            end
        end else if (en) begin
`ifdef BCD_CNT_SAT_EN
            if (step_s[W]) begin
                count_d = count_q;
            end else begin
                count_d = step_s[W-1:0];
            end
`else
            count_d = step_s[W-1:0];
            wrap_d  = step_s[W];
`endif
        end else begin
            count_d = count_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q    <= RST_BCD;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
    assign tc       = en & (up_dn ? (count_q == ALL_NINE) : (count_q == ALL_ZERO));

endmodule
